// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// text-segment defaults and the helper that sizes the legal PC span.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT    = 32'h0040_0000;
    localparam int          INSTR_BYTES          = 4;
    localparam int          MEMORY_DEPTH_DEFAULT = 64;

    // Byte offset from the text base to the last legal instruction word.
    function automatic int unsigned span_last_offset(input int unsigned depth);
        return (depth - 1) * INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable down-counter used to time the program-memory access.
// Load has priority, hold freezes the count, and it parks at zero.
module fetch_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             hold,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // Count down toward zero unless loading or held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (!hold && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program-memory requester for the multicycle datapath. Holds PC and IR,
// presents the PC as the fetch address, and captures the returned word
// once the configured access latency has elapsed.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              DATA_WIDTH   = 32,
    parameter int              MEMORY_DEPTH = MEMORY_DEPTH_DEFAULT,
    parameter logic [31:0]     TEXT_BASE    = TEXT_BASE_DEFAULT,
    parameter int              MEM_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_start_i,
    input  logic                  stall_i,
    input  logic                  pc_write_i,
    input  logic [DATA_WIDTH-1:0] pc_next_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic                  instr_valid_o,
    output logic                  busy_o,
    output logic                  addr_error_o
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_VALUE = CW'(MEM_LATENCY - 1);

    // Span limits kept one bit wider so the top of the address space cannot wrap.
    localparam logic [DATA_WIDTH:0] TEXT_FIRST = (DATA_WIDTH+1)'(TEXT_BASE);
    localparam logic [DATA_WIDTH:0] TEXT_LAST  =
        TEXT_FIRST + (DATA_WIDTH+1)'(span_last_offset(MEMORY_DEPTH));

    fetch_state_t          state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] ir_reg;
    logic [DATA_WIDTH-1:0] pending_pc_reg;
    logic                  pending_reg;
    logic                  instr_valid_reg;
    logic                  addr_error_reg;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  fetch_legal;
    logic                  fetch_accept;
    logic                  counter_load;
    logic                  counter_hold;
    logic                  counter_zero;
    logic [CW-1:0]         counter_count;

    assign pc_plus4 = pc_reg + DATA_WIDTH'(INSTR_BYTES);

    // Legal fetch: word aligned and inside the text segment.
    always_comb begin
        fetch_legal = (pc_reg[1:0] == 2'b00)
                   && ({1'b0, pc_reg} >= TEXT_FIRST)
                   && ({1'b0, pc_reg} <= TEXT_LAST);
    end

    // A request in IDLE counts only when no redirect is being taken that cycle.
    assign fetch_accept = (state_reg == ST_IDLE) && !pc_write_i && fetch_start_i && !stall_i;
    assign counter_load = fetch_accept && fetch_legal;
    assign counter_hold = stall_i || (state_reg != ST_WAIT);

    fetch_wait_counter #(
        .WIDTH (CW)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (counter_load),
        .hold       (counter_hold),
        .load_value (LOAD_VALUE),
        .count      (counter_count),
        .zero       (counter_zero)
    );

    // Fetch FSM with PC, IR, pending redirect and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= DATA_WIDTH'(TEXT_BASE);
            ir_reg          <= '0;
            pending_pc_reg  <= '0;
            pending_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
            addr_error_reg  <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pc_write_i) begin
                        pc_reg <= pc_next_i;
                    end else if (fetch_accept) begin
                        if (fetch_legal) begin
                            state_reg <= ST_WAIT;
                        end else begin
                            state_reg      <= ST_ERROR;
                            addr_error_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Redirects are deferred so the address stays stable during the access.
                    if (pc_write_i) begin
                        pending_reg    <= 1'b1;
                        pending_pc_reg <= pc_next_i;
                    end
                    if (!stall_i && counter_zero) begin
                        ir_reg          <= instruction_i;
                        instr_valid_reg <= 1'b1;
                        pending_reg     <= 1'b0;
                        state_reg       <= ST_IDLE;
                        if (pc_write_i) begin
                            pc_reg <= pc_next_i;
                        end else if (pending_reg) begin
                            pc_reg <= pending_pc_reg;
                        end else begin
                            pc_reg <= pc_plus4;
                        end
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_ERROR;
                end
            endcase
        end
    end

    assign address_o     = pc_reg;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_plus4;
    assign ir_o          = ir_reg;
    assign instr_valid_o = instr_valid_reg;
    assign busy_o        = (state_reg == ST_WAIT);
    assign addr_error_o  = addr_error_reg;

    // The wait count itself is only consumed through the zero flag.
    logic unused_count;
    assign unused_count = ^counter_count;

endmodule
